// File: rtl/cla_accum_pkg.sv
// cla_accum_pkg: shared widths, state encoding and saturation limit for the accumulation controller
package cla_accum_pkg;
  localparam int XW = 10;
  localparam int YW = 11;
  localparam int CNTW = 8;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam logic [YW-1:0] SAT_MAX = '1;
endpackage

// File: rtl/cla_sat_clip.sv
// cla_sat_clip: clips a W+1-bit unsigned sum to W bits, flagging overflow
module cla_sat_clip import cla_accum_pkg::*; #(
  parameter int W = YW
) (
  input  logic [W:0]   s,
  output logic [W-1:0] y,
  output logic         ovf
);
  assign ovf = s[W];
  assign y = ovf ? {W{1'b1}} : s[W-1:0];
endmodule

// File: rtl/cla_accum_ctrl.sv
// cla_accum_ctrl: streams samples through an external CLA adder into a saturating accumulator
module cla_accum_ctrl #(
  parameter int XW = cla_accum_pkg::XW,
  parameter int YW = cla_accum_pkg::YW,
  parameter int CNTW = cla_accum_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XW-1:0]   in_data,
  output logic [XW-1:0]   add_x,
  output logic [YW-1:0]   add_y,
  input  logic [YW:0]     add_s,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [YW-1:0]   out_data,
  output logic            out_sat,
  output logic            busy
);
  import cla_accum_pkg::*;
  state_t state, state_n;
  logic [YW-1:0] acc, acc_n, clip;
  logic [CNTW-1:0] cnt, cnt_n;
  logic sat, sat_n, ovf, accept;
  cla_sat_clip #(.W(YW)) u_clip (.s(add_s), .y(clip), .ovf(ovf));
  assign in_ready = state == ACC;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign accept = in_valid & in_ready;
  assign add_x = in_data;
  assign add_y = acc;
  // result outputs read as zero whenever no result is being offered
  assign out_data = out_valid ? acc : '0;
  assign out_sat = out_valid & sat;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    sat_n = sat;
    if (state == IDLE && start) begin
      acc_n = '0;
      sat_n = 1'b0;
      cnt_n = len;
      state_n = len == '0 ? DONE : ACC;
    end
    if (accept) begin
      acc_n = clip;
      sat_n = sat | ovf;
      cnt_n = cnt - CNTW'(1);
      state_n = cnt == CNTW'(1) ? DONE : ACC;
    end
    if (out_valid && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      sat <= sat_n;
    end
  end
endmodule

// File: tb/tb_cla_accum_ctrl.sv
// tb_cla_accum_ctrl: directed scenarios against a behavioural adder wrapped around the controller
module tb_cla_accum_ctrl;
  logic clk = 0;
  logic rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [7:0] len = 0;
  logic [9:0] in_data = 0;
  logic in_ready, out_valid, out_sat, busy;
  logic [9:0] add_x;
  logic [10:0] add_y, out_data;
  logic [11:0] add_s;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  // stands in for the carry look-ahead adder that sits beside the controller
  assign add_s = 12'(add_x) + 12'(add_y);
  cla_accum_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .add_x(add_x), .add_y(add_y),
    .add_s(add_s), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_data !== 11'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %0b expected 0", out_sat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (add_y !== 11'd0) begin n_fail++; $display("FAIL reset_acc: got %0d expected 0", add_y); end
  endtask
  task automatic test_basic();
    logic [9:0] d [3] = '{10'd100, 10'd200, 10'd300};
    start = 1; len = 3;
    tick();
    start = 0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d]: got %0b expected 0", i, out_valid); end
      in_valid = 1; in_data = d[i];
      tick();
    end
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %0b expected 1", out_valid); end
    n_checks++; if (out_data !== 11'd600) begin n_fail++; $display("FAIL basic_out_data: got %0d expected 600", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL basic_out_sat: got %0b expected 0", out_sat); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_in_ready: got %0b expected 0", in_ready); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy %0b expected 0", busy); end
  endtask
  task automatic test_saturate();
    logic [10:0] e [3] = '{11'd1023, 11'd2046, 11'd2047};
    start = 1; len = 3;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 10'd1023;
      tick();
      n_checks++; if (add_y !== e[i]) begin n_fail++; $display("FAIL sat_acc[%0d]: got %0d expected %0d", i, add_y, e[i]); end
    end
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_out_valid: got %0b expected 1", out_valid); end
    n_checks++; if (out_data !== 11'd2047) begin n_fail++; $display("FAIL sat_out_data: got %0d expected 2047", out_data); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sat_out_sat: got %0b expected 1", out_sat); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL sat_gated: got out_sat %0b expected 0", out_sat); end
  endtask
  task automatic test_len_zero();
    start = 1; len = 0;
    tick();
    start = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL len0_out_valid: got %0b expected 1", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL len0_in_ready: got %0b expected 0", in_ready); end
    n_checks++; if (out_data !== 11'd0) begin n_fail++; $display("FAIL len0_out_data: got %0d expected 0", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL len0_out_sat: got %0b expected 0", out_sat); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got busy %0b expected 0", busy); end
  endtask
  task automatic test_gapped();
    int xfers = 0;
    start = 1; len = 2;
    tick();
    start = 0;
    for (int c = 1; c <= 7; c++) begin
      in_valid = c == 2 || c == 7;
      in_data = c == 2 ? 10'd5 : 10'd9;
      if (c != 2 && c != 7) in_data = 10'd500;
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== 11'd14) begin n_fail++; $display("FAIL gap_hold[%0d]: got valid %0b data %0d expected valid 1 data 14", i, out_valid, out_data); end
      tick();
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) xfers++;
      tick();
    end
    out_ready = 0;
    n_checks++; if (xfers !== 1) begin n_fail++; $display("FAIL gap_transfers: got %0d expected 1", xfers); end
  endtask
  task automatic test_reset_mid();
    start = 1; len = 4;
    tick();
    start = 0;
    in_valid = 1; in_data = 10'd50;
    tick();
    in_data = 10'd60;
    tick();
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    n_checks++; if (add_y !== 11'd0) begin n_fail++; $display("FAIL rstmid_acc: got %0d expected 0", add_y); end
    start = 1; len = 1;
    tick();
    start = 0; in_valid = 1; in_data = 10'd7;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 11'd7) begin n_fail++; $display("FAIL rstmid_result: got valid %0b data %0d expected valid 1 data 7", out_valid, out_data); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  task automatic test_start_ignored();
    start = 1; len = 2;
    tick();
    in_valid = 1; in_data = 10'd10; len = 5;
    tick();
    start = 0; in_data = 10'd20;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 11'd30) begin n_fail++; $display("FAIL ign_result: got valid %0b data %0d expected valid 1 data 30", out_valid, out_data); end
    start = 1; len = 3;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 11'd30) begin n_fail++; $display("FAIL ign_done_start: got valid %0b data %0d expected valid 1 data 30", out_valid, out_data); end
    out_ready = 1;
    tick();
    start = 0; out_ready = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_handshake_busy: got %0b expected 0", busy); end
    tick();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ign_no_restart: got busy %0b in_ready %0b expected 0 0", busy, in_ready); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_len_zero();
    test_gapped();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
